nest_checker: RTL and testbench

NEST_CHECKER -- requirements
Module: nest_checker

---
 rtl/nest_checker.sv | 152 +++++++++++++++
 tb/tb_nest_checker.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nest_checker.sv
// Streaming begin/end and fork/join nesting checker over a space-delimited ASCII stream.
// Optional build macro: NEST_CHECKER_CASE_FOLD_EN (fold 'A'..'Z' onto 'a'..'z' before matching).
module nest_checker #(
    parameter int unsigned MAX_DEPTH = 8,
    parameter int unsigned DEPTH_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in,
    input  logic               in_valid,
    output logic               result,
    output logic [DEPTH_W-1:0] depth,
    output logic               error,
    output logic [1:0]         err_code
);

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNMATCHED = 2'b01,
        ERR_MISMATCH  = 2'b10,
        ERR_OVERFLOW  = 2'b11
    } err_e;

    localparam logic [7:0] DELIM   = 8'h20;
    localparam int unsigned NUM_KW = 4;

    // Keyword index: 0 begin, 1 fork, 2 end, 3 join; bit 0 of the index is the block type.
    function automatic logic [2:0] kw_len(input int unsigned k);
        case (k)
            0:       kw_len = 3'd5;
            1:       kw_len = 3'd4;
            2:       kw_len = 3'd3;
            default: kw_len = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] kw_char(input int unsigned k, input logic [2:0] p);
        logic [39:0] s;
        case (k)
            0:       s = "begin";
            1:       s = {"fork", 8'h00};
            2:       s = {"end", 16'h0000};
            default: s = {"join", 8'h00};
        endcase
        kw_char = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (p == 3'(i)) kw_char = s[8*(4-i) +: 8];
        end
    endfunction

    logic [2:0]           pos_q, pos_d;
    logic [NUM_KW-1:0]    flag_q, flag_d;
    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_q, err_d;
    err_e                 code_q, code_d;

    logic [7:0]           ch;
    logic [NUM_KW-1:0]    cur_flags;
    logic [NUM_KW-1:0]    pend;
    logic                 pend_open, pend_close, pend_type, top;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q   <= '0;
            flag_q  <= '0;
            stack_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            pos_q   <= pos_d;
            flag_q  <= flag_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
`ifdef NEST_CHECKER_CASE_FOLD_EN
        ch = (in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;
`else
        ch = in;
`endif
        // pos_q==0 marks the start of a word, so every keyword is still a candidate.
        cur_flags = (pos_q == '0) ? '1 : flag_q;
        for (int unsigned k = 0; k < NUM_KW; k++) begin
            pend[k] = flag_q[k] && (pos_q == kw_len(k));
        end
        pend_open  = pend[0] | pend[1];
        pend_close = pend[2] | pend[3];
        pend_type  = pend[1] | pend[3];

        top = 1'b0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            if (depth_q == DEPTH_W'(i + 1)) top = stack_q[i];
        end

        result = !err_q &&
                 ((!(|pend) && depth_q == '0) ||
                  (pend_close && depth_q == DEPTH_W'(1) && pend_type == top));

        pos_d   = pos_q;
        flag_d  = flag_q;
        stack_d = stack_q;
        depth_d = depth_q;
        err_d   = err_q;
        code_d  = code_q;

        if (in_valid && !err_q) begin
            if (in == DELIM) begin
                pos_d  = '0;
                flag_d = '0;
                if (pend_open) begin
                    if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVERFLOW;
                    end else begin
                        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
                            if (depth_q == DEPTH_W'(i)) stack_d[i] = pend_type;
                        end
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end else if (pend_close) begin
                    if (depth_q == '0) begin
                        err_d  = 1'b1;
                        code_d = ERR_UNMATCHED;
                    end else if (top != pend_type) begin
                        err_d  = 1'b1;
                        code_d = ERR_MISMATCH;
                    end else begin
                        depth_d = depth_q - DEPTH_W'(1);
                    end
                end
            end else begin
                // Position saturates at 6: any word past 5 bytes can no longer match.
                pos_d = (pos_q == 3'd6) ? pos_q : pos_q + 3'd1;
                for (int unsigned k = 0; k < NUM_KW; k++) begin
                    flag_d[k] = cur_flags[k] && (pos_q < kw_len(k)) &&
                                (ch == kw_char(k, pos_q));
                end
            end
        end
    end

    assign depth    = depth_q;
    assign error    = err_q;
    assign err_code = code_q;

endmodule

// File: tb/tb_nest_checker.sv
// Scoreboard bench for nest_checker (MAX_DEPTH=4): driver queues expectations, monitor compares after each edge.
module tb_nest_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in = 8'h00;
    logic       in_valid = 1'b0;
    logic       result;
    logic [2:0] depth;
    logic       error;
    logic [1:0] err_code;
    logic       tick = 1'b0;

    typedef struct packed {
        logic       chk;
        logic       r;
        logic [2:0] d;
        logic       e;
        logic [1:0] c;
    } exp_t;

    exp_t  sb_q[$];
    string nm_q[$];
    int    checks = 0;
    int    errors = 0;

    nest_checker #(.MAX_DEPTH(4), .DEPTH_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .result   (result),
        .depth    (depth),
        .error    (error),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            if (tick) begin
                exp_t  x;
                string nm;
                #1;
                if (sb_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scoreboard_underflow: got output with no expectation queued, required one");
                end else begin
                    x  = sb_q.pop_front();
                    nm = nm_q.pop_front();
                    if (x.chk) begin
                        checks++;
                        if (result !== x.r || depth !== x.d || error !== x.e || err_code !== x.c) begin
                            errors++;
                            $display("FAIL %s: got r=%0b d=%0d e=%0b c=%02b, required r=%0b d=%0d e=%0b c=%02b",
                                     nm, result, depth, error, err_code, x.r, x.d, x.e, x.c);
                        end
                    end
                end
            end
        end
    end

    task automatic push_drive(input byte c, input bit v, input bit chk, input string nm,
                              input bit r, input int d, input bit e, input int code);
        exp_t x;
        @(negedge clk);
        in       = c;
        in_valid = v;
        tick     = 1'b1;
        x.chk = chk;
        x.r   = r;
        x.d   = 3'(d);
        x.e   = e;
        x.c   = 2'(code);
        sb_q.push_back(x);
        nm_q.push_back(nm);
    endtask

    task automatic drvc(input byte c, input bit v, input string nm,
                        input bit r, input int d, input bit e, input int code);
        push_drive(c, v, 1'b1, nm, r, d, e, code);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) push_drive(s[i], 1'b1, 1'b0, "", 1'b0, 0, 1'b0, 0);
    endtask

    // Sends a string; only the state after its last byte is checked.
    task automatic sendc(input string s, input string nm,
                         input bit r, input int d, input bit e, input int code);
        for (int i = 0; i < s.len() - 1; i++) push_drive(s[i], 1'b1, 1'b0, "", 1'b0, 0, 1'b0, 0);
        drvc(s[s.len()-1], 1'b1, nm, r, d, e, code);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick     = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        do_reset();
        drvc(8'h00, 1'b0, "reset_state", 1, 0, 0, 0);

        send("begi");
        drvc("n", 1'b1, "open_pending", 0, 0, 0, 0);
        drvc(" ", 1'b1, "begin_d1", 0, 1, 0, 0);
        sendc("fork ", "fork_d2", 0, 2, 0, 0);
        sendc("join ", "join_d1", 0, 1, 0, 0);
        sendc("en", "en_partial", 0, 1, 0, 0);
        drvc("d", 1'b1, "end_pending_bal", 1, 1, 0, 0);
        drvc(" ", 1'b1, "end_d0", 1, 0, 0, 0);
        sendc("begin ", "rep_a", 0, 1, 0, 0);
        drvc(" ", 1'b1, "rep_delim_b", 0, 1, 0, 0);
        drvc(" ", 1'b1, "rep_delim_c", 0, 1, 0, 0);
        sendc("end  ", "rep_end", 1, 0, 0, 0);

        do_reset();
        sendc("begin join", "mis_pending", 0, 1, 0, 0);
        drvc(" ", 1'b1, "mis_err", 0, 1, 1, 2);
        sendc("end ", "mis_sticky", 0, 1, 1, 2);

        do_reset();
        sendc("end", "unm_pending", 0, 0, 0, 0);
        drvc(" ", 1'b1, "unm_err", 0, 0, 1, 1);
        sendc("begin ", "unm_freeze", 0, 0, 1, 1);

        do_reset();
        sendc("fork join", "fj_pending", 1, 1, 0, 0);
        drvc(" ", 1'b1, "fj_close", 1, 0, 0, 0);
        sendc("fork end ", "fork_end_err", 0, 1, 1, 2);

        do_reset();
        for (int i = 0; i < 4; i++) sendc("begin ", "ovf_fill", 0, i + 1, 0, 0);
        sendc("begin ", "ovf_err", 0, 4, 1, 3);
        sendc("end end end end ", "ovf_freeze", 0, 4, 1, 3);

        do_reset();
        sendc("beginx endd ", "ignore_ext", 1, 0, 0, 0);
        sendc("be beginbegin en joinjoin ", "ignore_long", 1, 0, 0, 0);
`ifdef NEST_CHECKER_CASE_FOLD_EN
        sendc("BEGIN ", "upper_case", 0, 1, 0, 0);
`else
        sendc("BEGIN ", "upper_case", 1, 0, 0, 0);
`endif

        do_reset();
        send("begin f");
        drvc(" ", 1'b0, "invalid_hold", 0, 1, 0, 0);
        drvc("x", 1'b0, "invalid_hold2", 0, 1, 0, 0);
        sendc("ork", "fork_pending", 0, 1, 0, 0);
        drvc(" ", 1'b1, "fork_commit", 0, 2, 0, 0);
        send("begin fo");
        do_reset();
        drvc(8'h00, 1'b0, "midstream_reset", 1, 0, 0, 0);
        sendc("rk ", "new_word_after_reset", 1, 0, 0, 0);

        @(negedge clk);
        tick     = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
